// File: rtl/pwm_demod_pkg.sv
// PWM link shared definitions: demod FSM state encodings and the
// default link sizing also used by the generator side.
package pwm_demod_pkg;

  localparam int PWM_DUTY_W = 8;
  localparam int PWM_PERIOD = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } pwm_st_e;

endpackage

// File: rtl/pwm_demod_sync_ff.sv
// Multi-flop level synchronizer for an asynchronous input line.
// Clears to 0 on asynchronous active-low reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sr_q;

  // shift the raw level through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sr_q[STAGES-1];

endmodule

// File: rtl/pwm_demod.sv
// PWM receiver: recovers high-time and period per PWM cycle.
// Optional 4-tap duty average when PWM_DEMOD_MOVAVG_EN is defined.
module pwm_demod
  import pwm_demod_pkg::*;
#(
  parameter int DUTY_W      = PWM_DUTY_W,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CNT_W-1:0]  period_out,
  output logic              duty_valid,
  output logic              signal_lost
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] DUTY_SAT = CNT_W'(2**DUTY_W - 1);

  logic s, s_prev_q, rise, fall;
  logic cap, tmo;

  pwm_st_e state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, per_q, per_d;
  logic [CNT_W-1:0] hi_inc, per_inc;
  logic [DUTY_W-1:0] hi_sat, cap_duty;

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic valid_q, valid_d;
  logic lost_q, lost_d;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pwm_in),
    .q_o  (s)
  );

  // previous synced level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev_q <= 1'b0;
    end else begin
      s_prev_q <= s;
    end
  end

  assign rise = s & ~s_prev_q;
  assign fall = ~s & s_prev_q;

  assign hi_inc  = (hi_q == CNT_MAX) ? hi_q : hi_q + CNT_ONE;
  assign per_inc = (per_q == CNT_MAX) ? per_q : per_q + CNT_ONE;
  assign hi_sat  = (hi_q > DUTY_SAT) ? {DUTY_W{1'b1}}
                                     : hi_q[DUTY_W-1:0];

  // line-tracking FSM and high/period counters
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    per_d   = per_q;
    cap     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          hi_d    = CNT_ONE;
          per_d   = CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (per_q == TMO) begin
          tmo = 1'b1;
        end else begin
          per_d = per_inc;
          if (fall) begin
            state_d = ST_LOW;
          end else begin
            hi_d = hi_inc;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          cap     = 1'b1;
          state_d = ST_HIGH;
          hi_d    = CNT_ONE;
          per_d   = CNT_ONE;
        end else if (per_q == TMO) begin
          tmo = 1'b1;
        end else begin
          per_d = per_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (tmo) begin
      state_d = ST_IDLE;
      hi_d    = '0;
      per_d   = '0;
    end
  end

`ifdef PWM_DEMOD_MOVAVG_EN
  localparam int SUM_W = DUTY_W + 2;

  logic [3:0][DUTY_W-1:0] hist_q, hist_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  // running sum over the last four captured duties
  always_comb begin
    hist_d = hist_q;
    sum_d  = sum_q;
    if (cap) begin
      sum_d  = sum_q - SUM_W'(hist_q[3]) + SUM_W'(hi_sat);
      hist_d = {hist_q[2:0], hi_sat};
    end else if (tmo) begin
      hist_d = '0;
      sum_d  = '0;
    end
  end

  // duty history and sum registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      sum_q  <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
    end
  end

  assign cap_duty = sum_d[SUM_W-1:2];
`else
  assign cap_duty = hi_sat;
`endif

  // capture and timeout output updates
  always_comb begin
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    lost_d   = lost_q;
    if (cap) begin
      duty_d   = cap_duty;
      period_d = per_q;
      valid_d  = 1'b1;
      lost_d   = 1'b0;
    end else if (tmo) begin
      duty_d   = {DUTY_W{s}};
      period_d = '0;
      valid_d  = 1'b1;
      lost_d   = 1'b1;
    end
  end

  // FSM, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      per_q    <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      per_q    <= per_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
    end
  end

  assign duty_out    = duty_q;
  assign period_out  = period_q;
  assign duty_valid  = valid_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Self-checking bench for pwm_demod: segment-level reference model
// of expected strobes, plus directed scenario checks.
module tb_pwm_demod;

  localparam int DUTY_W  = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1024;
  localparam int SYNC    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm_in = 1'b0;
  logic [DUTY_W-1:0] duty_out;
  logic [CNT_W-1:0] period_out;
  logic duty_valid;
  logic signal_lost;

  pwm_demod #(
    .DUTY_W     (DUTY_W),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .period_out (period_out),
    .duty_valid (duty_valid),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0]  period;
    logic              lost;
    int                gap;
  } ev_t;

  ev_t expq[$];
  ev_t me;
  int  got[$];
  int  vecs = 0;
  int  errs = 0;
  int  nstr = 0;
  int  last_cyc = 0;
  int  prev_cyc = 0;
  bit  dut_prev_v = 0;

  // reference model state (driven-line time domain)
  bit m_cur, m_act, m_prev_v;
  int m_rise, m_fall, m_prev_t;
  int hist[4];

  function automatic void m_push(int duty, int period, bit lost, int t);
    ev_t e;
    e.duty   = DUTY_W'(duty);
    e.period = CNT_W'(period);
    e.lost   = lost;
    e.gap    = m_prev_v ? t - m_prev_t : -1;
    m_prev_v = 1;
    m_prev_t = t;
    expq.push_back(e);
  endfunction

  function automatic int m_duty(int hi);
    int raw;
    raw = (hi > 255) ? 255 : hi;
`ifdef PWM_DEMOD_MOVAVG_EN
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = raw;
    return (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
    return raw;
`endif
  endfunction

  function automatic void m_reset();
    expq.delete();
    m_cur    = 0;
    m_act    = 0;
    m_prev_v = 0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
  endfunction

  // drive one constant-level segment of n clocks and predict strobes
  task automatic seg(input bit lvl, input int n);
    int t;
    t = cyc;
    if (lvl && !m_cur) begin
      if (m_act) m_push(m_duty(m_fall - m_rise), t - m_rise, 0, t);
      m_act  = 1;
      m_rise = t;
    end else if (!lvl && m_cur) begin
      m_fall = t;
    end
    m_cur  = lvl;
    pwm_in = lvl;
    if (m_act && (m_rise + TIMEOUT < t + n)) begin
      m_push(lvl ? 255 : 0, 0, 1, m_rise + TIMEOUT);
      m_act = 0;
      for (int i = 0; i < 4; i++) hist[i] = 0;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  // strobe monitor against the model's expected stream
  always @(negedge clk) begin
    if (!rst_n) begin
      dut_prev_v = 0;
    end else if (duty_valid) begin
      nstr++;
      prev_cyc = last_cyc;
      last_cyc = cyc;
      got.push_back(int'(duty_out));
      if (expq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_strobe got duty=%0d period=%0d want none",
                 duty_out, period_out);
      end else begin
        me = expq.pop_front();
        vecs++;
        if (duty_out !== me.duty) begin
          errs++;
          $display("FAIL strobe_duty got %0d want %0d", duty_out, me.duty);
        end
        vecs++;
        if (period_out !== me.period) begin
          errs++;
          $display("FAIL strobe_period got %0d want %0d",
                   period_out, me.period);
        end
        vecs++;
        if (signal_lost !== me.lost) begin
          errs++;
          $display("FAIL strobe_lost got %0b want %0b", signal_lost, me.lost);
        end
        if (me.gap >= 0 && dut_prev_v) begin
          vecs++;
          if (last_cyc - prev_cyc !== me.gap) begin
            errs++;
            $display("FAIL strobe_gap got %0d want %0d",
                     last_cyc - prev_cyc, me.gap);
          end
        end
      end
      dut_prev_v = 1;
    end
  end

  task automatic do_reset();
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    for (int i = 0; i < 8; i++) begin
      pwm_in = (i % 2 == 1);
      @(posedge clk);
    end
    @(negedge clk);
    vecs++;
    if (duty_out !== 8'd0) begin
      errs++;
      $display("FAIL reset_duty got %0d want 0", duty_out);
    end
    vecs++;
    if (period_out !== 16'd0) begin
      errs++;
      $display("FAIL reset_period got %0d want 0", period_out);
    end
    vecs++;
    if (duty_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_valid got %0b want 0", duty_valid);
    end
    vecs++;
    if (signal_lost !== 1'b1) begin
      errs++;
      $display("FAIL reset_lost got %0b want 1", signal_lost);
    end
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_steady();
    int n0;
    n0 = nstr;
    for (int i = 0; i < 6; i++) begin
      seg(1, 128);
      seg(0, 128);
    end
    seg(1, 10);
    @(negedge clk);
    vecs++;
    if (nstr - n0 !== 6) begin
      errs++;
      $display("FAIL steady_count got %0d want 6", nstr - n0);
    end
    vecs++;
    if (duty_out !== 8'd128 || period_out !== 16'd256) begin
      errs++;
      $display("FAIL steady_value got %0d/%0d want 128/256",
               duty_out, period_out);
    end
    vecs++;
    if (signal_lost !== 1'b0) begin
      errs++;
      $display("FAIL steady_lost got %0b want 0", signal_lost);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 15; i++) begin
      seg(1, $urandom_range(1, 300));
      seg(0, $urandom_range(1, 300));
    end
    seg(1, 10);
    vecs++;
    if (expq.size() !== 0) begin
      errs++;
      $display("FAIL random_pending got %0d want 0", expq.size());
    end
  endtask

  task automatic test_saturate();
    seg(0, 100);
    for (int i = 0; i < 4; i++) begin
      seg(1, 300);
      seg(0, 100);
    end
    seg(1, 10);
    @(negedge clk);
    vecs++;
    if (duty_out !== 8'd255 || period_out !== 16'd400) begin
      errs++;
      $display("FAIL saturate got %0d/%0d want 255/400",
               duty_out, period_out);
    end
  endtask

  task automatic test_timeout_low();
    for (int i = 0; i < 4; i++) begin
      seg(1, 64);
      seg(0, 192);
    end
    seg(1, 64);
    seg(0, 1100);
    @(negedge clk);
    vecs++;
    if (last_cyc - prev_cyc !== TIMEOUT) begin
      errs++;
      $display("FAIL tmo_low_delay got %0d want %0d",
               last_cyc - prev_cyc, TIMEOUT);
    end
    vecs++;
    if (duty_out !== 8'd0 || period_out !== 16'd0 || signal_lost !== 1'b1) begin
      errs++;
      $display("FAIL tmo_low got %0d/%0d/%0b want 0/0/1",
               duty_out, period_out, signal_lost);
    end
  endtask

  task automatic test_timeout_high();
    for (int i = 0; i < 3; i++) begin
      seg(1, 64);
      seg(0, 192);
    end
    seg(1, 1100);
    @(negedge clk);
    vecs++;
    if (last_cyc - prev_cyc !== TIMEOUT) begin
      errs++;
      $display("FAIL tmo_high_delay got %0d want %0d",
               last_cyc - prev_cyc, TIMEOUT);
    end
    vecs++;
    if (duty_out !== 8'd255 || period_out !== 16'd0 || signal_lost !== 1'b1) begin
      errs++;
      $display("FAIL tmo_high got %0d/%0d/%0b want 255/0/1",
               duty_out, period_out, signal_lost);
    end
    seg(0, 20);
  endtask

  task automatic test_idle_quiet();
    int n0;
    n0 = nstr;
    seg(0, 400);
    @(negedge clk);
    vecs++;
    if (nstr !== n0) begin
      errs++;
      $display("FAIL idle_strobes got %0d want 0", nstr - n0);
    end
    vecs++;
    if (duty_out !== 8'd255 || signal_lost !== 1'b1) begin
      errs++;
      $display("FAIL idle_hold got %0d/%0b want 255/1", duty_out, signal_lost);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    logic [DUTY_W-1:0] want;
`ifdef PWM_DEMOD_MOVAVG_EN
    want = 8'd75;
`else
    want = 8'd100;
`endif
    for (int i = 0; i < 3; i++) begin
      seg(1, 128);
      seg(0, 128);
    end
    seg(1, 50);
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (duty_out !== 8'd0 || period_out !== 16'd0 ||
        duty_valid !== 1'b0 || signal_lost !== 1'b1) begin
      errs++;
      $display("FAIL midreset got %0d/%0d/%0b/%0b want 0/0/0/1",
               duty_out, period_out, duty_valid, signal_lost);
    end
    pwm_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = nstr;
    for (int i = 0; i < 3; i++) begin
      seg(1, 100);
      seg(0, 156);
    end
    seg(1, 10);
    @(negedge clk);
    vecs++;
    if (nstr - n0 !== 3) begin
      errs++;
      $display("FAIL midreset_count got %0d want 3", nstr - n0);
    end
    vecs++;
    if (duty_out !== want || period_out !== 16'd256 || signal_lost !== 1'b0) begin
      errs++;
      $display("FAIL midreset_capture got %0d/%0d/%0b want %0d/256/0",
               duty_out, period_out, signal_lost, want);
    end
  endtask

  task automatic test_movavg();
    int hi[4];
    int want[4];
    hi = '{100, 200, 100, 200};
`ifdef PWM_DEMOD_MOVAVG_EN
    want = '{25, 75, 100, 150};
`else
    want = '{100, 200, 100, 200};
`endif
    do_reset();
    got.delete();
    for (int i = 0; i < 4; i++) begin
      seg(1, hi[i]);
      seg(0, 256 - hi[i]);
    end
    seg(1, 10);
    vecs++;
    if (got.size() !== 4) begin
      errs++;
      $display("FAIL movavg_count got %0d want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vecs++;
      if (got[i] !== want[i]) begin
        errs++;
        $display("FAIL movavg_duty%0d got %0d want %0d", i, got[i], want[i]);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_steady();
    test_random();
    test_saturate();
    test_timeout_low();
    test_timeout_high();
    test_idle_quiet();
    test_reset_mid();
    test_movavg();
    seg(0, 20);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
